// File: rtl/fp8_accum_stage_if.sv
// Handshake bundle for fp8_accum_stage: product stream in, group sum out.
// slave is the stage side, master is the producer/consumer side.
interface fp8_accum_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/fp8_accum_stage.sv
// Exact fixed-point FP8 group accumulator with FP8 renormalisation.
// Optional macro FP8_ACC_ROUND_NEAREST_EN: round-to-nearest-even on output.
module fp8_accum_stage #(
    parameter int MAX_TERMS = 16,
    parameter int ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    fp8_accum_stage_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_TERMS - 1);
    localparam logic [ACC_W-1:0] ONE = 1;

    localparam logic [1:0] S_ACC  = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_inf_pos;
    logic             r_inf_neg;
    logic [7:0]       r_out_data;
    logic             r_out_ovf;

    logic [2:0]       w_exp;
    logic [4:0]       w_fract;
    logic [2:0]       w_shift;
    logic [ACC_W-1:0] w_mag;
    logic [ACC_W-1:0] w_term;
    logic             w_is_inf;
    logic             w_fire;
    logic             w_close;

    logic             w_neg;
    logic [ACC_W-1:0] w_abs;
    int               w_p;
    logic [6:0]       w_em;
    logic             w_sat;
    logic [7:0]       w_nxt_data;
    logic             w_nxt_ovf;
`ifdef FP8_ACC_ROUND_NEAREST_EN
    logic             w_inc;
`endif

    assign w_exp    = bus.in_data[6:4];
    assign w_fract  = {w_exp != 3'd0, bus.in_data[3:0]};
    assign w_shift  = (w_exp == 3'd0) ? 3'd1 : w_exp;
    assign w_mag    = {{(ACC_W-5){1'b0}}, w_fract} << w_shift;
    assign w_term   = bus.in_data[7] ? (~w_mag + ONE) : w_mag;
    assign w_is_inf = (w_exp == 3'd7);
    assign w_fire   = bus.in_valid && (r_state == S_ACC);
    assign w_close  = bus.in_last || (r_cnt == LAST_CNT);

    assign w_neg = r_acc[ACC_W-1];
    assign w_abs = w_neg ? (~r_acc + ONE) : r_acc;

    // Leading-one position of the accumulator magnitude
    always_comb begin
        w_p = 0;
        for (int i = 0; i < ACC_W; i++) begin
            if (w_abs[i]) w_p = i;
        end
    end

    // Renormalise the sum to FP8, then let infinity flags override it
    always_comb begin
        w_em  = '0;
        w_sat = 1'b0;
`ifdef FP8_ACC_ROUND_NEAREST_EN
        w_inc = 1'b0;
`endif
        if (w_abs == '0) begin
            w_em = '0;
        end else if (w_p <= 4) begin
            w_em = {3'b000, w_abs[4:1]};
`ifdef FP8_ACC_ROUND_NEAREST_EN
            w_inc = w_abs[0] & w_abs[1];
`endif
        end else if (w_p <= 10) begin
            w_em = {3'(w_p - 4), 4'(w_abs >> (w_p - 4))};
`ifdef FP8_ACC_ROUND_NEAREST_EN
            w_inc = (|(w_abs & (ONE << (w_p - 5)))) &
                    ((|(w_abs & ((ONE << (w_p - 5)) - ONE))) | w_em[0]);
`endif
        end else begin
            w_sat = 1'b1;
        end
`ifdef FP8_ACC_ROUND_NEAREST_EN
        w_em = w_em + {6'b0, w_inc};
        if (w_em[6:4] == 3'b111) w_sat = 1'b1;
`endif
        if (r_inf_pos) begin
            w_nxt_data = 8'h70;
            w_nxt_ovf  = 1'b1;
        end else if (r_inf_neg) begin
            w_nxt_data = 8'hF0;
            w_nxt_ovf  = 1'b1;
        end else if (w_sat) begin
            w_nxt_data = {w_neg, 7'h70};
            w_nxt_ovf  = 1'b1;
        end else begin
            w_nxt_data = {w_neg, w_em};
            w_nxt_ovf  = 1'b0;
        end
    end

    // Group FSM: accumulate, normalise once, hold result until taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_ACC;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_inf_pos  <= 1'b0;
            r_inf_neg  <= 1'b0;
            r_out_data <= 8'h00;
            r_out_ovf  <= 1'b0;
        end else begin
            unique case (r_state)
                S_ACC: begin
                    if (w_fire) begin
                        if (w_is_inf) begin
                            if (bus.in_data[7]) r_inf_neg <= 1'b1;
                            else                r_inf_pos <= 1'b1;
                        end else begin
                            r_acc <= r_acc + w_term;
                        end
                        r_cnt <= r_cnt + 1'b1;
                        if (w_close) r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_out_data <= w_nxt_data;
                    r_out_ovf  <= w_nxt_ovf;
                    r_state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_acc     <= '0;
                        r_cnt     <= '0;
                        r_inf_pos <= 1'b0;
                        r_inf_neg <= 1'b0;
                        r_state   <= S_ACC;
                    end
                end
                default: r_state <= S_ACC;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_ACC);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_data  = r_out_data;
    assign bus.out_ovf   = r_out_ovf;
endmodule

// File: tb/tb_fp8_accum_stage.sv
// Randomised bench for fp8_accum_stage against a value-level model.
// Model works on integer sums and plain division-style rounding.
module tb_fp8_accum_stage;
    localparam int MAXT = 16;

    logic clk;
    logic rst;
    fp8_accum_stage_if bus();

    fp8_accum_stage #(.MAX_TERMS(MAXT), .ACC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    int   m_sum;
    bit   m_pinf;
    bit   m_ninf;
    int   m_cnt;
    logic [7:0] exp_d;
    logic       exp_o;
    logic [7:0] obs_d;
    logic       obs_o;
    logic [7:0] g_beats[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int term_val(input logic [7:0] d);
        int e;
        int m;
        int v;
        e = int'(d[6:4]);
        m = int'(d[3:0]);
        if (e == 0) v = m * 2;
        else        v = (16 + m) * (2 ** e);
        return d[7] ? -v : v;
    endfunction

    // returns {ovf, data}
    function automatic logic [8:0] model_norm(input int sum, input bit pinf,
                                              input bit ninf);
        int a;
        int p;
        int k;
        int q;
        int r;
        int half;
        int code;
        logic s;
        if (pinf) return {1'b1, 8'h70};
        if (ninf) return {1'b1, 8'hF0};
        s = (sum < 0);
        a = s ? -sum : sum;
        if (a == 0) return 9'h000;
        p = $clog2(a + 1) - 1;
        if (p >= 11) return {1'b1, s, 7'h70};
        k = (p <= 4) ? 1 : p - 4;
        q = a / (2 ** k);
        r = a - q * (2 ** k);
        half = 2 ** (k - 1);
        code = (p <= 4) ? q : ((p - 4) * 16 + (q - 16));
`ifdef FP8_ACC_ROUND_NEAREST_EN
        if (r > half || (r == half && (q % 2) == 1)) code++;
`endif
        if (code >= 'h70) return {1'b1, s, 7'h70};
        return {1'b0, s, 7'(code)};
    endfunction

    task automatic model_clear();
        m_sum  = 0;
        m_pinf = 0;
        m_ninf = 0;
        m_cnt  = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l,
                             output bit closed);
        logic [8:0] res;
        chk("in_ready_acc", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (d[6:4] == 3'd7) begin
            if (d[7]) m_ninf = 1;
            else      m_pinf = 1;
        end else begin
            m_sum += term_val(d);
        end
        m_cnt++;
        closed = l || (m_cnt == MAXT);
        if (closed) begin
            res = model_norm(m_sum, m_pinf, m_ninf);
            exp_o = res[8];
            exp_d = res[7:0];
            model_clear();
        end
    endtask

    task automatic run_group(input bit mark_last, input int hold);
        bit closed;
        int n;
        int idx;
        logic [7:0] first_d;
        n = g_beats.size();
        closed = 0;
        for (idx = 0; idx < n && !closed; idx++) begin
            send_beat(g_beats[idx], mark_last && (idx == n - 1), closed);
        end
        chk("group_len", idx, n);
        chk("group_closed", closed, 1'b1);
        if (!closed) return;
        chk("norm_valid", bus.out_valid, 1'b0);
        chk("norm_ready", bus.in_ready, 1'b0);
        tick();
        chk("lat_valid", bus.out_valid, 1'b1);
        chk("hold_ready", bus.in_ready, 1'b0);
        first_d = bus.out_data;
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom_range(0, 255));
            bus.in_last  = 1'($urandom_range(0, 1));
            tick();
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_ready", bus.in_ready, 1'b0);
            chk("stall_data", bus.out_data, first_d);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        obs_d = bus.out_data;
        obs_o = bus.out_ovf;
        chk("out_data", obs_d, exp_d);
        chk("out_ovf", obs_o, exp_o);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("done_valid", bus.out_valid, 1'b0);
        chk("done_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        bit c;
        logic [7:0] d;
        n_chk  = 0;
        n_fail = 0;
        model_clear();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #12;
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 8'h00);
        chk("rst_out_ovf", bus.out_ovf, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        g_beats = '{8'h38, 8'h38};
        run_group(1, 0);
        chk("dir_38_38", obs_d, 8'h48);
        chk("dir_38_38_ovf", obs_o, 1'b0);

        g_beats = '{8'h38, 8'hB8};
        run_group(1, 0);
        chk("dir_cancel", obs_d, 8'h00);

        g_beats = '{8'h01};
        run_group(1, 0);
        chk("dir_subn", obs_d, 8'h01);

        g_beats = '{8'h68, 8'h68};
        run_group(1, 0);
        chk("dir_sat", obs_d, 8'h70);
        chk("dir_sat_ovf", obs_o, 1'b1);

        g_beats = '{8'hF5};
        run_group(1, 0);
        chk("dir_ninf", obs_d, 8'hF0);
        chk("dir_ninf_ovf", obs_o, 1'b1);

        g_beats = '{8'h39, 8'h39, 8'h39};
        run_group(1, 0);
`ifdef FP8_ACC_ROUND_NEAREST_EN
        chk("dir_round", obs_d, 8'h53);
`else
        chk("dir_trunc", obs_d, 8'h52);
`endif

        g_beats = {};
        for (int i = 0; i < MAXT; i++) g_beats.push_back(8'h38);
        run_group(0, 0);
        chk("dir_force", obs_d, 8'h70);

        g_beats = {};
        for (int i = 0; i < MAXT; i++) g_beats.push_back(8'h02);
        run_group(1, 0);
        g_beats = '{8'h38};
        run_group(1, 0);
        chk("dir_one_group", obs_d, 8'h38);

        g_beats = '{8'h40, 8'h21};
        run_group(1, 5);

        send_beat(8'h38, 1'b0, c);
        send_beat(8'h38, 1'b0, c);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 1'b0);
        chk("mid_rst_ready", bus.in_ready, 1'b1);
        tick();
        rst = 1'b0;
        model_clear();
        tick();
        g_beats = '{8'h38};
        run_group(1, 0);
        chk("post_rst", obs_d, 8'h38);

        for (int g = 0; g < 40; g++) begin
            int n;
            n = $urandom_range(1, MAXT);
            g_beats = {};
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) d[6] = 1'b0;
                g_beats.push_back(d);
            end
            run_group((n < MAXT) || ($urandom_range(0, 1) == 1),
                      $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
